fetch_queue: RTL and testbench

Instruction queue between the 2-wide fetch stage and decode. Accepts each fetch bundle (valid mask, PCs, instructions), compacts valid slots in program order into a circular buffer, and presents up to FETCH_W oldest entries to decode. Generates the fetch-stall backpressure and is emptied on branch redirect.

---
 rtl/fetch_queue.sv | 136 +++++++++++++
 tb/tb_fetch_queue.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: compacting instruction queue between 2-wide fetch and decode.
// Ports: clk/reset, flush, in_valid/in_pc/in_instr, fq_stall, dec_*, fq_count, ovf_err. Option: FQ_BYPASS_EN.
module fetch_queue #(
  parameter int XLEN    = 32,
  parameter int FETCH_W = 2,
  parameter int DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [FETCH_W-1:0]            in_valid,
  input  logic [FETCH_W-1:0][XLEN-1:0]  in_pc,
  input  logic [FETCH_W-1:0][XLEN-1:0]  in_instr,
  output logic                          fq_stall,
  output logic [FETCH_W-1:0]            dec_valid,
  output logic [FETCH_W-1:0][XLEN-1:0]  dec_pc,
  output logic [FETCH_W-1:0][XLEN-1:0]  dec_instr,
  input  logic                          dec_ready,
  output logic [$clog2(DEPTH+1)-1:0]    fq_count,
  output logic                          ovf_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [XLEN-1:0] mem_pc    [DEPTH];
  logic [XLEN-1:0] mem_instr [DEPTH];

  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;

  logic [CW-1:0] slot_pos [FETCH_W];
  logic [CW-1:0] n_in, n_q, n_out, free;
  logic [FETCH_W-1:0][XLEN-1:0] comp_pc, comp_instr;
  logic [FETCH_W-1:0][XLEN-1:0] q_pc, q_instr;
  logic [FETCH_W-1:0] q_valid;
  logic take, do_enq, drop;

  // Compact valid input slots: slot i lands at position popcount(valid[i-1:0]).
  always_comb begin
    logic [CW-1:0] pos;
    pos = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      slot_pos[i] = pos;
      pos = pos + CW'(in_valid[i]);
    end
    n_in = pos;
    for (int j = 0; j < FETCH_W; j++) begin
      comp_pc[j]    = '0;
      comp_instr[j] = '0;
      for (int i = 0; i < FETCH_W; i++) begin
        if (in_valid[i] && slot_pos[i] == CW'(j)) begin
          comp_pc[j]    = in_pc[i];
          comp_instr[j] = in_instr[i];
        end
      end
    end
  end

  always_comb begin
    logic [AW-1:0] idx;
    idx = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      idx        = head + AW'(i);
      q_pc[i]    = mem_pc[idx];
      q_instr[i] = mem_instr[idx];
      q_valid[i] = count > CW'(i);
    end
  end

  assign n_q  = (count >= CW'(FETCH_W)) ? CW'(FETCH_W) : count;
  assign free = CW'(DEPTH) - count;

`ifdef FQ_BYPASS_EN
  logic byp;
  assign byp = (count == '0) && !flush;

  always_comb begin
    dec_pc    = q_pc;
    dec_instr = q_instr;
    dec_valid = q_valid;
    if (byp) begin
      dec_pc    = comp_pc;
      dec_instr = comp_instr;
      for (int i = 0; i < FETCH_W; i++) dec_valid[i] = n_in > CW'(i);
    end
  end

  // Bypassed slots consumed by decode never enter storage.
  assign take  = byp && dec_ready;
  assign n_out = take ? n_in : (dec_ready ? n_q : '0);
`else
  assign dec_pc    = q_pc;
  assign dec_instr = q_instr;
  assign dec_valid = q_valid;
  assign take      = 1'b0;
  assign n_out     = dec_ready ? n_q : '0;
`endif

  // Acceptance uses the pre-cycle count; a bundle is never split.
  assign do_enq = !flush && !take && (n_in != '0) && (n_in <= free);
  assign drop   = !flush && (n_in > free);

  assign fq_stall = free < CW'(2*FETCH_W);
  assign fq_count = count;

  always_ff @(posedge clk) begin
    if (!reset && do_enq) begin
      for (int j = 0; j < FETCH_W; j++) begin
        if (CW'(j) < n_in) begin
          mem_pc[tail + AW'(j)]    <= comp_pc[j];
          mem_instr[tail + AW'(j)] <= comp_instr[j];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      ovf_err <= 1'b0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_enq) tail <= tail + AW'(n_in);
      if (!take) head <= head + AW'(n_out);
      count <= count + (do_enq ? n_in : '0) - (take ? '0 : n_out);
      if (drop) ovf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized scoreboard bench for fetch_queue.
// Queue-of-entries reference model; monitor pops expected entries on consumption.
module tb_fetch_queue;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic [1:0] in_valid = '0;
  logic [1:0][31:0] in_pc = '0;
  logic [1:0][31:0] in_instr = '0;
  logic fq_stall;
  logic [1:0] dec_valid;
  logic [1:0][31:0] dec_pc;
  logic [1:0][31:0] dec_instr;
  logic dec_ready = 1'b0;
  logic [3:0] fq_count;
  logic ovf_err;

  fetch_queue #(.XLEN(32), .FETCH_W(2), .DEPTH(8)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .fq_stall(fq_stall), .dec_valid(dec_valid),
    .dec_pc(dec_pc), .dec_instr(dec_instr),
    .dec_ready(dec_ready), .fq_count(fq_count), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

`ifdef FQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  ent_t mq[$];
  ent_t exp_q[$];
  bit movf = 1'b0;
  int npass = 0;
  int ntot = 0;
  logic [31:0] pc_ctr = 32'h100;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [1:0] thermo(input int n);
    return (n >= 2) ? 2'b11 : (n == 1) ? 2'b01 : 2'b00;
  endfunction

  task automatic check_status();
    int sz;
    sz = mq.size();
    chk("fq_count", 32'(fq_count), 32'(sz));
    chk("fq_stall", 32'(fq_stall), 32'((8 - sz) < 4));
    chk("ovf_err", 32'(ovf_err), 32'(movf));
`ifdef FQ_BYPASS_EN
    if (sz != 0) chk("dec_valid", 32'(dec_valid), 32'(thermo(sz)));
`else
    chk("dec_valid", 32'(dec_valid), 32'(thermo(sz)));
`endif
    if (sz != 0) begin
      chk("dec_pc0", dec_pc[0], mq[0].pc);
      chk("dec_instr0", dec_instr[0], mq[0].ins);
    end
  endtask

  task automatic model_step(input logic [1:0] v, input logic [31:0] p0, i0, p1, i1,
                            input logic rdy, fl, rst);
    ent_t b[$];
    int nout;
    if (rst) begin
      mq.delete(); exp_q.delete(); movf = 1'b0;
      return;
    end
    if (fl) begin
      mq.delete(); exp_q.delete();
      return;
    end
    if (v[0]) b.push_back('{pc: p0, ins: i0});
    if (v[1]) b.push_back('{pc: p1, ins: i1});
    if (BYP && mq.size() == 0 && rdy) begin
      foreach (b[k]) exp_q.push_back(b[k]);
      return;
    end
    nout = rdy ? ((mq.size() >= 2) ? 2 : mq.size()) : 0;
    if (b.size() <= 8 - mq.size()) begin
      foreach (b[k]) begin
        mq.push_back(b[k]);
        exp_q.push_back(b[k]);
      end
    end else begin
      movf = 1'b1;
    end
    repeat (nout) void'(mq.pop_front());
  endtask

  task automatic cyc(input logic [1:0] v, input logic [31:0] p0, i0, p1, i1,
                     input logic rdy, fl, rst);
    @(negedge clk);
    check_status();
    reset = rst; flush = fl; dec_ready = rdy;
    in_valid = v;
    in_pc[0] = p0; in_instr[0] = i0;
    in_pc[1] = p1; in_instr[1] = i1;
    model_step(v, p0, i0, p1, i1, rdy, fl, rst);
  endtask

  task automatic seq2(input logic [1:0] v, input logic rdy, input logic fl);
    logic [31:0] p0, p1;
    p0 = pc_ctr;
    p1 = pc_ctr + 32'd4;
    pc_ctr = pc_ctr + 32'd8;
    cyc(v, p0, $urandom, p1, $urandom, rdy, fl, 1'b0);
  endtask

  task automatic idle(input logic rdy);
    cyc(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, rdy, 1'b0, 1'b0);
  endtask

  // Monitor: whatever decode consumes must match the oldest expected entries.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      #4;
      if (!reset && !flush && dec_ready) begin
        for (int i = 0; i < 2; i++) begin
          if (dec_valid[i]) begin
            if (exp_q.size() == 0) begin
              ntot++;
              $display("FAIL deq_extra: slot %0d pc %h, expected none", i, dec_pc[i]);
            end else begin
              e = exp_q.pop_front();
              chk("deq_pc", dec_pc[i], e.pc);
              chk("deq_instr", dec_instr[i], e.ins);
            end
          end
        end
      end
    end
  end

  initial begin
    cyc(2'b00, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    cyc(2'b00, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    // In-order pair of bundles with decode ready
    cyc(2'b11, 32'h00, 32'h11111111, 32'h04, 32'h22222222, 1'b1, 1'b0, 1'b0);
    cyc(2'b11, 32'h08, 32'h33333333, 32'h0C, 32'h44444444, 1'b1, 1'b0, 1'b0);
    idle(1'b1); idle(1'b1); idle(1'b1);
    // Upper slot only
    cyc(2'b10, 32'h10, 32'h55555555, 32'h14, 32'h66666666, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1); idle(1'b1);
    // Fill to full, then overflow
    repeat (5) seq2(2'b11, 1'b0, 1'b0);
    idle(1'b0);
    repeat (5) idle(1'b1);
    // Fill 7 across the wrap, then drain
    repeat (3) seq2(2'b11, 1'b0, 1'b0);
    seq2(2'b01, 1'b0, 1'b0);
    repeat (5) idle(1'b1);
    // Flush with simultaneous input and dequeue
    repeat (2) seq2(2'b11, 1'b0, 1'b0);
    seq2(2'b11, 1'b1, 1'b1);
    idle(1'b0);
    idle(1'b1);
    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [1:0] v;
      logic rdy, fl, rst;
      logic [31:0] p0, p1;
      v   = 2'($urandom);
      rdy = ($urandom_range(0, 9) < 6);
      fl  = ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 499) == 0);
      p0  = pc_ctr;
      p1  = pc_ctr + 32'd4;
      pc_ctr = pc_ctr + 32'd8;
      cyc(v, p0, $urandom, p1, $urandom, rdy, fl, rst);
    end
    repeat (6) idle(1'b1);
    @(negedge clk);
    check_status();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
